// File: rtl/audio_pkg.sv
// Shared sample types, fill policy and writer state encoding for the codec playback path.
package audio_pkg;

  localparam int SAMPLE_W = 24;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef struct packed {
    sample_t l;
    sample_t r;
  } stereo_t;

  typedef enum logic [1:0] {
    FILL_NONE = 2'd0,
    FILL_HOLD = 2'd1,
    FILL_ZERO = 2'd2
  } fill_mode_e;

  // Bit 0 of the encoding is the codec write strobe, so write comes straight off a flop.
  typedef enum logic [1:0] {
    WR_IDLE  = 2'b00,
    WR_DRAIN = 2'b01,
    WR_FILL  = 2'b11
  } wr_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// Stereo sample FIFO; power-of-two depth so pointers wrap naturally.
module audio_sample_fifo
  import audio_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   CLOCK_50,
  input  logic                   reset_n,
  input  logic                   push,
  input  stereo_t                push_data,
  input  logic                   pop,
  output stereo_t                head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  stereo_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // A full FIFO refuses a push even when a pop happens on the same edge.
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge CLOCK_50) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/audio_dac_writer.sv
// Buffers processed stereo samples and feeds the codec write interface, filling on underflow.
//
// state    | meaning
// WR_IDLE  | no codec write this cycle (codec not ready, or empty FIFO with FILL_NONE)
// WR_DRAIN | writing the sample popped from the FIFO head
// WR_FILL  | writing the fill sample (last sample or zero) because the FIFO was empty
module audio_dac_writer
  import audio_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int FILL_MODE = 1,
  parameter int MONO      = 0
) (
  input  logic        CLOCK_50,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] in_left,
  input  logic [23:0] in_right,
  input  logic        write_ready,
  output logic        write,
  output logic [23:0] writedata_left,
  output logic [23:0] writedata_right,
  output logic [15:0] underflow_cnt,
  output logic        overflow
);

  localparam fill_mode_e FMODE = fill_mode_e'(FILL_MODE[1:0]);

  wr_state_e             state_q, state_d;
  stereo_t               data_q, data_d;
  stereo_t               last_q, last_d;
  logic [15:0]           ucnt_q, ucnt_d;
  logic                  ovf_q, ovf_d;

  stereo_t               push_data;
  stereo_t               fifo_head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                  push;
  logic                  pop;

  assign in_ready    = !fifo_full;
  assign push        = in_valid && in_ready;
  assign push_data.l = (MONO != 0) ? in_right : in_left;
  assign push_data.r = in_right;

  audio_sample_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .CLOCK_50 (CLOCK_50),
    .reset_n  (reset_n),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_comb begin
    state_d = WR_IDLE;
    data_d  = data_q;
    last_d  = last_q;
    ucnt_d  = ucnt_q;
    pop     = 1'b0;
    ovf_d   = ovf_q | (in_valid && fifo_full);
    if (write_ready) begin
      if (fifo_count != '0) begin
        state_d = WR_DRAIN;
        data_d  = fifo_head;
        last_d  = fifo_head;
        pop     = 1'b1;
      end else if (fifo_empty) begin
        // Same-edge pushes are not visible here; they drain on the following edge.
        ucnt_d = sat_inc16(ucnt_q);
        case (FMODE)
          FILL_HOLD: begin
            state_d = WR_FILL;
            data_d  = last_q;
          end
          FILL_ZERO: begin
            state_d = WR_FILL;
            data_d  = '0;
          end
          default: state_d = WR_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= WR_IDLE;
      data_q  <= '0;
      last_q  <= '0;
      ucnt_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      last_q  <= last_d;
      ucnt_q  <= ucnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign write           = state_q[0];
  assign writedata_left  = data_q.l;
  assign writedata_right = data_q.r;
  assign underflow_cnt   = ucnt_q;
  assign overflow        = ovf_q;

endmodule

// File: tb/tb_audio_dac_writer.sv
// Scoreboard bench: four writers (fill modes 0/1/2 and a mono variant) share one stimulus stream.
module tb_audio_dac_writer;

  localparam int DEPTH = 8;
  localparam int NI    = 4;

  typedef struct packed {
    logic [23:0] l;
    logic [23:0] r;
  } smp_t;

  typedef struct {
    int          cyc;
    logic [23:0] l;
    logic [23:0] r;
  } exp_t;

  logic        CLOCK_50 = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [23:0] in_left;
  logic [23:0] in_right;
  logic        write_ready;

  logic        in_ready_o [NI];
  logic        write_o    [NI];
  logic [23:0] wl_o       [NI];
  logic [23:0] wr_o       [NI];
  logic [15:0] ucnt_o     [NI];
  logic        ovf_o      [NI];

  always #5 CLOCK_50 = ~CLOCK_50;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    audio_dac_writer #(
      .DEPTH    (DEPTH),
      .FILL_MODE((g == 3) ? 1 : g),
      .MONO     ((g == 3) ? 1 : 0)
    ) u_dut (
      .CLOCK_50       (CLOCK_50),
      .reset_n        (reset_n),
      .in_valid       (in_valid),
      .in_ready       (in_ready_o[g]),
      .in_left        (in_left),
      .in_right       (in_right),
      .write_ready    (write_ready),
      .write          (write_o[g]),
      .writedata_left (wl_o[g]),
      .writedata_right(wr_o[g]),
      .underflow_cnt  (ucnt_o[g]),
      .overflow       (ovf_o[g])
    );
  end

  // Reference model: a plain queue per instance plus the fill rules.
  int   mode [NI] = '{0, 1, 2, 1};
  bit   mono [NI] = '{0, 0, 0, 1};
  smp_t mfifo [NI][$];
  exp_t exp_q [NI][$];
  smp_t mlast [NI];
  int   mucnt [NI];
  bit   movf  [NI];

  int cyc_n  = 0;
  int checks = 0;
  int errors = 0;
  bit mon_en = 0;

  task automatic chk(input string name, input int i, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s dut%0d: got %0d want %0d (cycle %0d)", name, i, act, req, cyc_n);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      mfifo[i].delete();
      exp_q[i].delete();
      mlast[i] = '0;
      mucnt[i] = 0;
      movf[i]  = 0;
    end
  endtask

  task automatic model_step();
    smp_t s;
    exp_t e;
    bit   room;
    for (int i = 0; i < NI; i++) begin
      room = (mfifo[i].size() != DEPTH);
      if (write_ready) begin
        if (mfifo[i].size() > 0) begin
          s = mfifo[i].pop_front();
          mlast[i] = s;
          e.cyc = cyc_n; e.l = s.l; e.r = s.r;
          exp_q[i].push_back(e);
        end else begin
          if (mucnt[i] < 65535) mucnt[i]++;
          if (mode[i] == 1) begin
            e.cyc = cyc_n; e.l = mlast[i].l; e.r = mlast[i].r;
            exp_q[i].push_back(e);
          end else if (mode[i] == 2) begin
            e.cyc = cyc_n; e.l = '0; e.r = '0;
            exp_q[i].push_back(e);
          end
        end
      end
      if (in_valid) begin
        if (room) begin
          s.l = mono[i] ? in_right : in_left;
          s.r = in_right;
          mfifo[i].push_back(s);
        end else begin
          movf[i] = 1;
        end
      end
    end
  endtask

  task automatic drive(input bit v, input logic [23:0] l, input logic [23:0] r, input bit wr);
    in_valid    = v;
    in_left     = l;
    in_right    = r;
    write_ready = wr;
    @(posedge CLOCK_50);
    cyc_n++;
    model_step();
    #1;
  endtask

  // Monitor: pops the scoreboard whenever a DUT presents a write.
  always @(negedge CLOCK_50) begin
    exp_t e;
    if (mon_en) begin
      for (int i = 0; i < NI; i++) begin
        while (exp_q[i].size() > 0 && exp_q[i][0].cyc < cyc_n) begin
          e = exp_q[i].pop_front();
          checks++;
          errors++;
          $display("FAIL write_missed dut%0d: got no write want R=%0d at cycle %0d", i, e.r, e.cyc);
        end
        if (write_o[i]) begin
          if (exp_q[i].size() > 0 && exp_q[i][0].cyc == cyc_n) begin
            e = exp_q[i].pop_front();
            chk("write_left", i, wl_o[i], e.l);
            chk("write_right", i, wr_o[i], e.r);
          end else begin
            chk("write_unexpected", i, 1, 0);
          end
        end
        chk("in_ready", i, in_ready_o[i], (mfifo[i].size() != DEPTH));
        chk("underflow_cnt", i, ucnt_o[i], mucnt[i]);
        chk("overflow", i, ovf_o[i], movf[i]);
      end
    end
  end

  initial begin
    reset_n     = 1'b0;
    in_valid    = 1'b0;
    in_left     = '0;
    in_right    = '0;
    write_ready = 1'b1;
    model_reset();
    #3;
    for (int i = 0; i < NI; i++) begin
      chk("rst_write", i, write_o[i], 0);
      chk("rst_wdata_r", i, wr_o[i], 0);
      chk("rst_in_ready", i, in_ready_o[i], 1);
    end
    #9 reset_n = 1'b1;
    mon_en = 1;

    // Underflow straight out of reset.
    repeat (3) drive(0, '0, '0, 1);
    for (int i = 0; i < NI; i++) begin
      chk("t1_ucnt", i, ucnt_o[i], 3);
      chk("t1_write", i, write_o[i], (i == 0) ? 0 : 1);
    end

    // Back-to-back stream, then fill after the last sample.
    for (int k = 0; k < 8; k++) drive(1, 24'($urandom), 24'(1000000 + k), 1);
    drive(0, '0, '0, 1);
    chk("t2_last", 0, wr_o[0], 1000007);
    repeat (3) drive(0, '0, '0, 1);
    chk("t2_hold", 1, wr_o[1], 1000007);
    chk("t2_hold_mono_l", 3, wl_o[3], 1000007);
    chk("t2_zero", 2, wr_o[2], 0);
    chk("t2_none", 0, write_o[0], 0);

    // Overfill with the codec stalled, then drain.
    for (int k = 0; k < 10; k++) drive(1, 24'($urandom), 24'(2000000 + k), 0);
    chk("t3_in_ready", 0, in_ready_o[0], 0);
    chk("t3_overflow", 0, ovf_o[0], 1);
    repeat (10) drive(0, '0, '0, 1);

    // Full FIFO with push and pop on one edge.
    for (int k = 0; k < 8; k++) drive(1, 24'($urandom), 24'(3000000 + k), 0);
    drive(1, 24'h123456, 24'd3999999, 1);
    chk("t5_in_ready", 0, in_ready_o[0], 1);
    repeat (9) drive(0, '0, '0, 1);

    // Reset mid-burst drops write immediately.
    for (int k = 0; k < 6; k++) drive(1, 24'($urandom), 24'(4000000 + k), 0);
    drive(0, '0, '0, 1);
    #6;
    for (int i = 0; i < NI; i++) chk("t6_pre_write", i, write_o[i], 1);
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("t6_rst_write", i, write_o[i], 0);
      chk("t6_rst_wdata_l", i, wl_o[i], 0);
      chk("t6_rst_ucnt", i, ucnt_o[i], 0);
      chk("t6_rst_ovf", i, ovf_o[i], 0);
      chk("t6_rst_in_ready", i, in_ready_o[i], 1);
    end
    model_reset();
    #1 reset_n = 1'b1;
    drive(1, 24'd77, 24'd5000000, 1);
    drive(0, '0, '0, 1);
    for (int i = 0; i < NI; i++) begin
      chk("t6_first_write", i, write_o[i], 1);
      chk("t6_first_data", i, wr_o[i], 5000000);
    end

    // Randomised traffic with varying producer/codec duty.
    for (int p = 0; p < 4; p++) begin
      for (int n = 0; n < 120; n++) begin
        drive(($urandom_range(0, 3) < p + 1), 24'($urandom), 24'($urandom),
              ($urandom_range(0, 3) >= p));
      end
    end

    repeat (2) drive(0, '0, '0, 0);
    @(negedge CLOCK_50);
    #2;
    for (int i = 0; i < NI; i++) chk("leftover_expected", i, exp_q[i].size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
